// File: rtl/servisia_lcd_ctrl.sv
// Wishbone controller for an HD44780 16x2 LCD in 8-bit write-only mode.
// Define SERVISIA_LCD_FIFO_EN for a 4-entry command FIFO; otherwise a single holding register is used.
module servisia_lcd_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned EN_CYC    = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned EXEC_CYC  = 40,
  parameter int unsigned CLR_CYC   = 1600
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [8:0] wb_dat_i,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  output logic [8:0] wb_rdt_o,
  output logic       wb_ack_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_db_o
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    EXEC   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       q_empty;
  logic       q_full;
  logic [8:0] q_head;
  logic       rd_c;
  logic       push_c;
  logic       pop_c;
  logic       busy_c;
  logic       is_clr_c;

  // Bus handshake: ack can never repeat on consecutive cycles because it gates itself.
  assign rd_c     = wb_stb_i & ~wb_we_i & ~wb_ack_o;
  assign push_c   = wb_stb_i & wb_we_i & ~wb_ack_o & ~q_full;
  assign pop_c    = (state == IDLE) & ~q_empty;
  assign busy_c   = (state != IDLE) | ~q_empty;
  assign is_clr_c = ~lcd_rs_o && (lcd_db_o != 8'd0) && (lcd_db_o <= 8'd3);

`ifdef SERVISIA_LCD_FIFO_EN
  logic [8:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] count;

  always_ff @(posedge clk_i) begin
    if (push_c) mem[wp] <= wb_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push_c) wp <= wp + 2'd1;
      if (pop_c)  rp <= rp + 2'd1;
      case ({push_c, pop_c})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign q_empty = (count == 3'd0);
  assign q_full  = (count == 3'd4);
  assign q_head  = mem[rp];
`else
  logic [8:0] hold_q;
  logic       hold_vld;

  // Push requires an empty register, so push and pop never coincide here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_q   <= 9'd0;
      hold_vld <= 1'b0;
    end else if (push_c) begin
      hold_q   <= wb_dat_i;
      hold_vld <= 1'b1;
    end else if (pop_c) begin
      hold_vld <= 1'b0;
    end
  end

  assign q_empty = ~hold_vld;
  assign q_full  = hold_vld;
  assign q_head  = hold_q;
`endif

  // Bus response plus the LCD timing sequencer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_rdt_o <= 9'd0;
      lcd_rs_o <= 1'b0;
      lcd_en_o <= 1'b0;
      lcd_db_o <= 8'd0;
    end else begin
      wb_ack_o <= rd_c | push_c;
      wb_rdt_o <= rd_c ? {7'd0, q_full, busy_c} : 9'd0;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            lcd_rs_o <= q_head[8];
            lcd_db_o <= q_head[7:0];
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_en_o <= 1'b1;
            cnt      <= EN_LD;
            state    <= ENABLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            lcd_en_o <= 1'b0;
            cnt      <= HOLD_LD;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_clr_c ? CLR_LD : EXEC_LD;
            state <= EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servisia_lcd_ctrl.sv
// Directed bench for servisia_lcd_ctrl; timing expectations are counted in clock edges.
module tb_servisia_lcd_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [8:0] wb_dat_i;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic [8:0] wb_rdt_o;
  logic       wb_ack_o;
  logic       lcd_rs_o;
  logic       lcd_en_o;
  logic [7:0] lcd_db_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] log_q[$];
  logic       prev_en = 1'b0;

  servisia_lcd_ctrl dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wb_dat_i (wb_dat_i),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_rdt_o (wb_rdt_o),
    .wb_ack_o (wb_ack_o),
    .lcd_rs_o (lcd_rs_o),
    .lcd_en_o (lcd_en_o),
    .lcd_db_o (lcd_db_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Records {rs, db} at every EN rising edge.
  always @(posedge clk_i) begin
    if (lcd_en_o && !prev_en) log_q.push_back({lcd_rs_o, lcd_db_o});
    prev_en <= lcd_en_o;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) step();
  endtask

  task automatic bus_write(input logic [8:0] d, output int ack_cyc);
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_dat_i = d;
    for (int i = 0; i < 300; i++) begin
      step();
      if (wb_ack_o) break;
    end
    check("wr_ack", 32'(wb_ack_o), 32'd1);
    ack_cyc  = cyc;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic bus_read(output logic [8:0] d);
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    step();
    check("rd_ack", 32'(wb_ack_o), 32'd1);
    d        = wb_rdt_o;
    wb_stb_i = 1'b0;
  endtask

  initial begin
    int         w;
    int         p;
    int         w2;
    int         p2;
    int         en_seen;
    logic [8:0] d;

    rst_ni   = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_dat_i = 9'd0;

    // Power-on reset
    repeat (3) step();
    check("rst_outs", 32'({wb_ack_o, wb_rdt_o, lcd_rs_o, lcd_en_o, lcd_db_o}), 32'd0);
    rst_ni = 1'b1;
    step();

    // Data write 'A' with RS=1
    bus_write(9'h141, w);
    p = w + 1;
    step();
    check("a_rs", 32'(lcd_rs_o), 32'd1);
    check("a_db", 32'(lcd_db_o), 32'h41);
    check("a_en_setup", 32'(lcd_en_o), 32'd0);
    step();
    check("a_en_rise", 32'(lcd_en_o), 32'd1);
    step();
    check("a_en_high2", 32'(lcd_en_o), 32'd1);
    step();
    check("a_en_fall", 32'(lcd_en_o), 32'd0);
    check("a_db_hold", 32'(lcd_db_o), 32'h41);

    // Continuous polling: ack alternates, rdt only valid with ack
    wait_to(p + 10);
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("poll_ack", 32'(wb_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("poll_rdt", 32'(wb_rdt_o), (i % 2 == 0) ? 32'h001 : 32'h000);
    end
    wb_stb_i = 1'b0;

    wait_to(p + 43);
    bus_read(d);
    check("a_busy_p44", 32'(d), 32'h001);
    wait_to(p + 55);
    bus_read(d);
    check("a_idle", 32'(d), 32'h000);

    // Clear display command uses the long wait
    step();
    bus_write(9'h001, w);
    p = w + 1;
    step();
    check("clr_rs", 32'(lcd_rs_o), 32'd0);
    check("clr_db", 32'(lcd_db_o), 32'h01);
    wait_to(p + 49);
    bus_read(d);
    check("clr_busy_p50", 32'(d), 32'h001);
    wait_to(p + 1603);
    bus_read(d);
    check("clr_busy_p1604", 32'(d), 32'h001);
    wait_to(p + 1605);
    bus_read(d);
    check("clr_idle_p1606", 32'(d), 32'h000);

    // Reset in the middle of the EN pulse
    step();
    bus_write(9'h155, w);
    p = w + 1;
    wait_to(p + 1);
    check("rst_en_pre", 32'(lcd_en_o), 32'd1);
    rst_ni = 1'b0;
    step();
    check("rst_en_drop", 32'(lcd_en_o), 32'd0);
    step();
    step();
    check("rst_mid_outs", 32'({wb_ack_o, wb_rdt_o, lcd_rs_o, lcd_en_o, lcd_db_o}), 32'd0);
    rst_ni = 1'b1;
    bus_read(d);
    check("rst_read", 32'(d), 32'h000);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (lcd_en_o) en_seen = 1;
    end
    check("rst_no_strobe", 32'(en_seen), 32'd0);

    log_q.delete();
    step();
`ifdef SERVISIA_LCD_FIFO_EN
    // Six back-to-back writes: four fill the FIFO behind the first pop, the sixth stalls
    begin
      int         acks[6];
      logic [8:0] vals[6];
      for (int k = 0; k < 6; k++) vals[k] = 9'h141 + 9'(k);
      for (int k = 0; k < 5; k++) bus_write(vals[k], acks[k]);
      check("fifo_ack_span", 32'(acks[4] - acks[0]), 32'd8);
      step();
      bus_read(d);
      check("fifo_full_flag", 32'(d), 32'h003);
      bus_write(vals[5], acks[5]);
      check("fifo_6th_ack", 32'(acks[5] - acks[0]), 32'd47);
      wait_to(acks[0] + 280);
      check("fifo_log_size", 32'(log_q.size()), 32'd6);
      for (int k = 0; k < 6; k++)
        check("fifo_order", 32'((log_q.size() > k) ? log_q[k] : 9'h1ff), 32'(vals[k]));
      bus_read(d);
      check("fifo_idle", 32'(d), 32'h000);
    end
`else
    // Two back-to-back writes: the second waits for the holding register to empty
    bus_write(9'h148, w);
    p = w + 1;
    wb_dat_i = 9'h069;
    bus_write(9'h069, w2);
    check("b2b_ack2_cyc", 32'(w2 - p), 32'd1);
    wait_to(p + 9);
    bus_read(d);
    check("b2b_full_flag", 32'(d), 32'h003);
    p2 = p + 45;
    wait_to(p2);
    check("b2b_rs2", 32'(lcd_rs_o), 32'd0);
    check("b2b_db2", 32'(lcd_db_o), 32'h69);
    wait_to(p2 + 44);
    bus_read(d);
    check("b2b_idle_p45", 32'(d), 32'h000);
    check("b2b_log_size", 32'(log_q.size()), 32'd2);
    check("b2b_log0", 32'((log_q.size() > 0) ? log_q[0] : 9'h1ff), 32'h148);
    check("b2b_log1", 32'((log_q.size() > 1) ? log_q[1] : 9'h1ff), 32'h069);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
